// File: rtl/bbfifo_param_if.sv
// Write/read/status bundle between the byte receiver, bbfifo_param and the command decoder.
interface bbfifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              flush;
  logic [DATA_W-1:0] data_in;
  logic              write;
  logic              read;
  logic              clear_err;
  logic [DATA_W-1:0] data_out;
  logic              data_present;
  logic              full;
  logic              half_full;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, data_in, write, read, clear_err,
    input  data_out, data_present, full, half_full, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  flush, data_in, write, read, clear_err,
    output data_out, data_present, full, half_full, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/bbfifo_param.sv
// Single-clock first-word-fall-through FIFO with fill level, thresholds, flush and sticky errors.
// Latency: write-to-data_out 1 cycle when empty; flags and level update on the accepting edge.
// Backpressure: writes to a full FIFO are dropped (overflow) unless a pop happens the same cycle.
module bbfifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = 24,
  parameter int AE_LEVEL = 4,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           reset,
  bbfifo_param_if.slave bus
);
  localparam int LVL_W = ADDR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_HALF = LVL_W'(DEPTH / 2);
  localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_LEVEL);
  localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic              overflow_q;
  logic              underflow_q;

  logic is_full;
  logic is_empty;
  logic rd_ok;
  logic wr_ok;
  logic ovf_evt;
  logic unf_evt;

  assign is_full  = (level_q == LVL_FULL);
  assign is_empty = (level_q == '0);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a write alongside it.
  assign rd_ok   = ~bus.flush & bus.read & ~is_empty;
  assign wr_ok   = ~bus.flush & bus.write & (~is_full | rd_ok);
  assign ovf_evt = ~bus.flush & bus.write & ~wr_ok;
  assign unf_evt = ~bus.flush & bus.read & is_empty;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_q <= '0;
      end else begin
        if (wr_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (rd_ok) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (wr_ok && !rd_ok) begin
          level_q <= level_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
          level_q <= level_q - 1'b1;
        end
      end
      // A new error in the same cycle as clear_err wins.
      overflow_q  <= (overflow_q & ~bus.clear_err) | ovf_evt;
      underflow_q <= (underflow_q & ~bus.clear_err) | unf_evt;
    end
  end

  assign bus.data_out     = is_empty ? '0 : mem[rd_ptr];
  assign bus.data_present = ~is_empty;
  assign bus.full         = is_full;
  assign bus.half_full    = (level_q >= LVL_HALF);
  assign bus.almost_full  = (level_q >= LVL_AF);
  assign bus.almost_empty = (level_q <= LVL_AE);
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_bbfifo_param.sv
// Directed and randomized bench for bbfifo_param against a queue-based reference model.
module tb_bbfifo_param;
  localparam int DW = 8;
  localparam int D  = 32;
  localparam int AF = 24;
  localparam int AE = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bbfifo_param_if #(.DATA_W(DW), .DEPTH(D)) bus ();

  bbfifo_param #(
    .DATA_W  (DW),
    .DEPTH   (D),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int            total = 0;
  int            bad   = 0;
  string         phase = "reset";
  logic [DW-1:0] mq[$];
  bit            m_ov = 1'b0;
  bit            m_un = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s %s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] head();
    return (mq.size() != 0) ? 32'(mq[0]) : 32'd0;
  endfunction

  task automatic check_all();
    int n = mq.size();
    check("level",        32'(bus.level),        32'(n));
    check("data_out",     32'(bus.data_out),     head());
    check("data_present", 32'(bus.data_present), 32'(n != 0));
    check("full",         32'(bus.full),         32'(n == D));
    check("half_full",    32'(bus.half_full),    32'(n >= D / 2));
    check("almost_full",  32'(bus.almost_full),  32'(n >= AF));
    check("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
    check("overflow",     32'(bus.overflow),     32'(m_ov));
    check("underflow",    32'(bus.underflow),    32'(m_un));
  endtask

  task automatic model_step(input bit w, input bit r, input logic [DW-1:0] d,
                            input bit fl, input bit ce);
    int n   = mq.size();
    bit pop = r && (n > 0);
    bit psh = w && ((n < D) || pop);
    if (ce) begin
      m_ov = 1'b0;
      m_un = 1'b0;
    end
    if (fl) begin
      mq.delete();
    end else begin
      if (w && !psh) m_ov = 1'b1;
      if (r && n == 0) m_un = 1'b1;
      if (pop) void'(mq.pop_front());
      if (psh) mq.push_back(d);
    end
  endtask

  // Drive one cycle; data_out is checked before the edge (no write-through) and everything after.
  task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d,
                       input bit fl = 1'b0, input bit ce = 1'b0);
    bus.write     = w;
    bus.read      = r;
    bus.data_in   = d;
    bus.flush     = fl;
    bus.clear_err = ce;
    #1;
    check("pre_edge_data_out", 32'(bus.data_out), head());
    @(posedge clk);
    model_step(w, r, d, fl, ce);
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.write     = 1'b0;
    bus.read      = 1'b0;
    bus.data_in   = '0;
    bus.flush     = 1'b0;
    bus.clear_err = 1'b0;

    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    check("reset_almost_empty", 32'(bus.almost_empty), 32'd1);

    phase = "every_other_write";
    for (int i = 1; i <= 17; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      cycle(1'b0, 1'b0, 8'h00);
    end
    check("level17",    32'(bus.level),     32'd17);
    check("half17",     32'(bus.half_full), 32'd1);
    check("head17",     32'(bus.data_out),  32'h01);
    for (int i = 1; i <= 17; i++) begin
      check("read_order", 32'(bus.data_out), 32'(i));
      cycle(1'b0, 1'b1, 8'h00);
    end
    check("drained_present", 32'(bus.data_present), 32'd0);
    check("drained_data",    32'(bus.data_out),     32'd0);

    phase = "overflow";
    for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, 8'(i));
    cycle(1'b1, 1'b0, 8'hAA);
    check("ovf_flag",  32'(bus.overflow), 32'd1);
    check("ovf_full",  32'(bus.full),     32'd1);
    check("ovf_level", 32'(bus.level),    32'd32);
    for (int i = 0; i < D; i++) begin
      check("ovf_drain", 32'(bus.data_out), 32'(i));
      cycle(1'b0, 1'b1, 8'h00);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_cleared", 32'(bus.overflow), 32'd0);

    phase = "full_streaming";
    for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, 8'(i));
    for (int k = 0; k < 40; k++) cycle(1'b1, 1'b1, 8'(D + k));
    check("stream_level", 32'(bus.level),    32'd32);
    check("stream_head",  32'(bus.data_out), 32'd40);
    for (int i = 0; i < D; i++) cycle(1'b0, 1'b1, 8'h00);

    phase = "underflow";
    cycle(1'b0, 1'b1, 8'h00);
    check("unf_flag", 32'(bus.underflow), 32'd1);
    cycle(1'b1, 1'b1, 8'h55);
    check("unf_rw_level", 32'(bus.level),    32'd1);
    check("unf_rw_data",  32'(bus.data_out), 32'h55);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    check("unf_set_wins", 32'(bus.underflow), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    phase = "thresholds";
    for (int i = 1; i <= D; i++) begin
      cycle(1'b1, 1'b0, 8'($urandom));
      check("af_up", 32'(bus.almost_full),  32'(i >= AF));
      check("ae_up", 32'(bus.almost_empty), 32'(i <= AE));
    end
    for (int i = D - 1; i >= 0; i--) begin
      cycle(1'b0, 1'b1, 8'h00);
      check("hf_down", 32'(bus.half_full), 32'(i >= 16));
    end

    phase = "flush";
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i));
    cycle(1'b1, 1'b0, 8'h77, 1'b1);
    check("flush_level",   32'(bus.level),        32'd0);
    check("flush_present", 32'(bus.data_present), 32'd0);
    check("flush_ovf",     32'(bus.overflow),     32'd0);

    phase = "random";
    for (int k = 0; k < 600; k++) begin
      int wb = (k < 300) ? 70 : 35;
      int rb = (k < 300) ? 35 : 70;
      cycle($urandom_range(0, 99) < wb, $urandom_range(0, 99) < rb, 8'($urandom),
            $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
    end

    phase = "async_reset";
    for (int i = 0; i < 12; i++) cycle(1'b1, ($urandom_range(0, 3) == 0), 8'($urandom));
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b0, 8'h99);
    bus.write = 1'b1;
    bus.data_in = 8'h3C;
    #2;
    reset = 1'b1;
    #1;
    mq.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 1'b0, 8'h5A);
    cycle(1'b0, 1'b1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
